// File: rtl/hdmi_video_timing.sv
// Raster timing generator for HDMI/DVI: pixel/line counters, data-enable and syncs,
// gated on a synchronized PLL lock. All outputs are registered and decoded from next state.
module hdmi_video_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_locked,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_num,
    output logic          running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    // The state register is the second stage of the lock synchronizer, so the
    // first RUN cycle coincides with locked_s rising (two edges after pll_locked).
    logic   lock_meta_q;
    state_t state_q, state_d;

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic [7:0]    frame_num_q, frame_num_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          running_q, running_d;
    logic          hs_act, vs_act;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (lock_meta_q)  state_d = RUN;
            RUN:       if (!lock_meta_q) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        hcount_d    = '0;
        vcount_d    = '0;
        frame_num_d = frame_num_q;
        // Counters only advance when already running; entering RUN starts at (0,0).
        if (state_d == RUN && state_q == RUN) begin
            if (hcount_q == H_LAST) begin
                if (vcount_q == V_LAST) begin
                    frame_num_d = frame_num_q + 8'd1;
                end else begin
                    vcount_d = vcount_q + ONE;
                end
            end else begin
                hcount_d = hcount_q + ONE;
                vcount_d = vcount_q;
            end
        end

        running_d     = (state_d == RUN);
        hs_act        = running_d && (hcount_d >= HS_BEG) && (hcount_d < HS_END);
        vs_act        = running_d && (vcount_d >= VS_BEG) && (vcount_d < VS_END);
        de_d          = running_d && (hcount_d < H_ACT) && (vcount_d < V_ACT);
        hsync_d       = hs_act ? H_POL : ~H_POL;
        vsync_d       = vs_act ? V_POL : ~V_POL;
        line_start_d  = running_d && (hcount_d == '0);
        frame_start_d = line_start_d && (vcount_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q   <= 1'b0;
            state_q       <= WAIT_LOCK;
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_num_q   <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            lock_meta_q   <= pll_locked;
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_num_q   <= frame_num_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_num   = frame_num_q;
    assign running     = running_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing on a shrunken raster (15x10) so frame_num wrap fits in a short run.
module tb_hdmi_video_timing;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CW = 10;
    localparam int W = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic [CW-1:0] hcount, vcount;
    logic          de, hsync, vsync, line_start, frame_start, running;
    logic [7:0]    frame_num;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state: running flag, cycles since timing started, frame count,
    // and the pll_locked value seen at the previous edge.
    bit m_run  = 1'b0;
    int m_pos  = 0;
    int m_fnum = 0;
    bit m_prev = 1'b0;

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hcount(hcount), .vcount(vcount), .de(de), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
        .frame_num(frame_num), .running(running)
    );

    always #20 clk = ~clk;

    function automatic logic [W-1:0] model_out(input bit run, input int pos, input int fnum);
        int h, v;
        bit e_de, e_hs, e_vs, e_ls, e_fs;
        if (!run) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(fnum), 1'b0};
        h    = pos % HT;
        v    = (pos / HT) % VT;
        e_de = (h < HA) && (v < VA);
        e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e_ls = (h == 0);
        e_fs = (h == 0) && (v == 0);
        return {10'(h), 10'(v), e_de, e_hs, e_vs, e_ls, e_fs, 8'(fnum), 1'b1};
    endfunction

    task automatic check(input string name, input logic [W-1:0] e);
        logic [W-1:0] a;
        a = {hcount, vcount, de, hsync, vsync, line_start, frame_start, frame_num, running};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s t=%0t got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fn=%0d run=%b want h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b fn=%0d run=%b",
                     name, $time, a[33:24], a[23:14], a[13], a[12], a[11], a[10], a[9], a[8:1], a[0],
                     e[33:24], e[23:14], e[13], e[12], e[11], e[10], e[9], e[8:1], e[0]);
        end
    endtask

    // Model advance at each active edge, using the inputs as they stood at that edge.
    task automatic model_edge();
        bit nr;
        if (rst) begin
            m_run  = 1'b0;
            m_prev = 1'b0;
            m_fnum = 0;
            m_pos  = 0;
        end else begin
            nr = m_prev;
            if (nr) begin
                if (!m_run) m_pos = 0;
                else begin
                    m_pos++;
                    if (m_pos % FRAME == 0) m_fnum = (m_fnum + 1) % 256;
                end
            end
            m_run  = nr;
            m_prev = pll_locked;
        end
        exp_q.push_back(model_out(m_run, m_pos, m_fnum));
    endtask

    // One clock cycle of stimulus: optional sub-period lock glitch, then reset change.
    task automatic step(input bit rst_v, input bit pll_v, input bit glitch);
        @(negedge clk);
        #2 pll_locked = pll_v;
        if (glitch) begin
            pll_locked = ~pll_v;
            #5 pll_locked = pll_v;
        end else begin
            #5;
        end
        #3;
        if (rst_v && !rst) begin
            rst = 1'b1;
            #1 check("async_rst", model_out(1'b0, 0, 0));
        end else if (!rst_v && rst) begin
            rst = 1'b0;
        end
        @(posedge clk);
        #1 model_edge();
    endtask

    // Monitor: every cycle presents one output word, compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle", exp_q.pop_front());
    end

    initial begin
        bit pll_cur;
        int r;
        rst        = 1'b1;
        pll_locked = 1'b0;
        #1 check("reset_state", model_out(1'b0, 0, 0));
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // Release reset, raise lock at cycle 10, run a little over two frames.
        repeat (7) step(1'b0, 1'b0, 1'b0);
        repeat (2 * FRAME + 20) step(1'b0, 1'b1, 1'b0);

        // Drop lock at (5,3), stay unlocked, then relock: frame_num must be kept.
        for (int i = 0; i < FRAME && !(m_run && (m_pos % FRAME == 3 * HT + 5)); i++)
            step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        repeat (FRAME + 40) step(1'b0, 1'b1, 1'b0);

        // Async reset while inside hsync, release with lock high.
        for (int i = 0; i < HT && !(m_run && (m_pos % HT == HA + HF + 1)); i++)
            step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (2 * HT) step(1'b0, 1'b1, 1'b0);

        // Long run with glitches to carry frame_num through 255 -> 0.
        repeat (257 * FRAME + 10) step(1'b0, 1'b1, ($urandom_range(0, 19) == 0));

        // Random lock drops, reset pulses and glitches.
        pll_cur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 299));
            if (r == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b1, pll_cur, 1'b0);
            end else begin
                if (r < 4) pll_cur = ~pll_cur;
                step(1'b0, pll_cur, (r >= 280));
            end
        end
        repeat (100) step(1'b0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d queued want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
- Generates 640x480@60 raster timing in the 25.2 MHz pixel-clock domain driven by the HDMI PLL's pixel output.
- Gates on the PLL lock indication.
- Feeds the pixel source and the TMDS encoders: pixel coordinates, data-enable, and sync levels.
- Emits per-line and per-frame strobes plus a frame counter for pattern/animation logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock, 25.2 MHz
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- hcount  out  CW  current pixel column
- vcount  out  CW  current line
- de  out  1  active-video enable
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- line_start  out  1  one-cycle pulse at hcount=0
- frame_start  out  1  one-cycle pulse at hcount=0, vcount=0
- frame_num  out  8  frame counter
- running  out  1  timing active

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high. All flops reset asynchronously; all outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values:
  - hcount=0, vcount=0, de=0, line_start=0, frame_start=0, frame_num=0, running=0
  - hsync=~H_POL, vsync=~V_POL (inactive levels)
  - lock synchronizer flops=0; state=WAIT_LOCK
- Lock synchronizer: two-flop synchronizer on pll_locked produces locked_s, which rises 2 clk edges after pll_locked rises.
- FSM, two states:
  - WAIT_LOCK: all outputs held at reset values. Go to RUN when locked_s=1.
  - RUN: running=1; counters advance every cycle. Go to WAIT_LOCK when locked_s=0. On the next edge all outputs return to reset values, counters clear, and frame_num is retained.
- First RUN cycle: hcount=0, vcount=0, de=1, line_start=1, frame_start=1, frame_num unchanged.
- Counters in RUN:
  - hcount increments by 1; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - At hcount=H_TOTAL-1 and vcount=V_TOTAL-1, both wrap to 0 and frame_num increments. frame_num wraps 255->0.
- Decodes: all outputs in a cycle describe the hcount/vcount presented in that same cycle (zero skew; decode from next-state values).
  - de = (hcount<H_ACTIVE) && (vcount<V_ACTIVE)
  - hsync active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vsync active for full lines V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, all hcount values
  - line_start = (hcount==0); frame_start = line_start && (vcount==0)
- Async rst mid-frame: outputs go to reset values immediately. After release, the block waits for locked_s (2 edges minimum if pll_locked is already high), then restarts at (0,0).
- pll_locked glitch shorter than one clk period: may or may not be caught. If caught, timing restarts cleanly at (0,0) with no partial-frame corruption of sync widths.
- No other inputs; no backpressure.

Test Plan:
- Reset, then raise pll_locked at cycle 10 -> running=1 and frame_start=1 at the 2nd following edge, with hcount=0, vcount=0, de=1.
- Run one full line -> de high for exactly 640 cycles; hsync low for cycles 656..751 (96 cycles); line_start period 800 cycles.
- Run one full frame -> vsync low for exactly 1600 cycles (lines 490-491); frame_start period 420000 cycles; de total 307200 cycles.
- Wrap check at (799,524) -> next cycle (0,0), frame_start=1, frame_num +1. Run 256 frames (or force frame_num=255) -> frame_num wraps to 0.
- Drop pll_locked at (300,200) -> 2 edges later outputs at reset values and running=0. Re-raise -> restart at (0,0) with frame_num retained.
- Assert rst asynchronously mid-hsync -> hsync=1, de=0, counters 0 without waiting for a clk edge. Release with pll_locked high -> restart after 2 edges.
